btn_debounce: RTL and testbench

- Front-end conditioning stage for the board pushbutton, directly upstream of the LED blink timer.
- Synchronises the raw asynchronous button and debounces it by requiring a stable input for a programmable interval.
- Emits a clean level plus single-cycle press, release and (optional) long-press strobes. The press strobe drives the blink timer's active-high rst.
- Single clock domain, 100 MHz nominal.

---
 rtl/btn_debounce.sv | 142 ++++++++++++++
 tb/tb_btn_debounce.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces the raw board pushbutton.
// Outputs are a clean level and one-cycle press and release strobes.
// Optional long-press strobe, built in only when the macro BTN_LONGPRESS_EN
// is defined; otherwise long_pulse is tied low. The port list is the same
// in both builds.
`timescale 1ns/1ps

module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 2) &&
                             (LONG_CYCLES >= 2);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Refuse to build with parameter values the counters cannot represent.
  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("btn_debounce: SYNC_STAGES, DEBOUNCE_CYCLES and LONG_CYCLES must all be >= 2");
    end
  endgenerate

  // Debounce counter step; the caller guarantees the value is below CNT_LAST,
  // so the increment can never wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // ---- Stage p0: input synchroniser -------------------------------------
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // ---- Stage p1: debounce counter, level and edge strobes ---------------
  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             release_nxt;

  // Count consecutive disagreeing cycles; restart on every agreement, and
  // flip the level once the disagreement has lasted the full interval.
  always_comb begin
    cnt_nxt     = '0;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (sync_out != btn_level) begin
      if (cnt_p1 == CNT_LAST) begin
        level_nxt   = sync_out;
        press_nxt   = sync_out;
        release_nxt = ~sync_out;
      end else begin
        cnt_nxt = cnt_inc(cnt_p1);
      end
    end
  end

  // Register the counter, level and strobes; strobes line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      cnt_p1        <= cnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef BTN_LONGPRESS_EN
  // ---- Stage p2: long-press hold timer ----------------------------------
  localparam int               HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_p2;
  logic [HOLD_W-1:0] hold_nxt;
  logic              done_p2;
  logic              done_nxt;
  logic              long_nxt;

  // Time the hold while the level is high; fire once, then park until release.
  always_comb begin
    hold_nxt = '0;
    done_nxt = 1'b0;
    long_nxt = 1'b0;
    if (btn_level) begin
      hold_nxt = hold_p2;
      done_nxt = done_p2;
      if (!done_p2) begin
        if (hold_p2 == HOLD_LAST) begin
          done_nxt = 1'b1;
          long_nxt = 1'b1;
        end else begin
          hold_nxt = hold_p2 + HOLD_W'(1);
        end
      end
    end
  end

  // Register the hold timer, its one-shot flag and the long-press strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_p2    <= '0;
      done_p2    <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      hold_p2    <= hold_nxt;
      done_p2    <= done_nxt;
      long_pulse <= long_nxt;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios plus randomized button
// activity, checked against an edge-indexed history model of the button.
`timescale 1ns/1ps

module tb_btn_debounce;

  localparam int SS = 2;
  localparam int DC = 8;
  localparam int LC = 32;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: samp[k] is btn_raw as seen at edge k after reset,
  // lvl[k] is the expected debounced level just after edge k.
  logic samp [0:HMAX-1];
  logic lvl  [0:HMAX-1];
  int   e;
  logic exp_level, exp_press, exp_release, exp_long;
  int   press_cnt, release_cnt, long_cnt;
  int   last_press_e, last_release_e, last_long_e;

  btn_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic sync_at(int j);
    if (j < 1) return 1'b0;
    return samp[j];
  endfunction

  task automatic model_reset();
    e = 0;
    samp[0] = 1'b0;
    lvl[0]  = 1'b0;
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    last_press_e = -1; last_release_e = -1; last_long_e = -1;
    exp_level = 1'b0; exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0;
  endtask

  // Advance one clock edge and compute what the outputs should be after it.
  // The level flips when the synchronised input disagreed with the old level
  // on every one of the last DC edges.
  task automatic tick();
    logic r;
    logic flip;
    r = btn_raw;
    @(posedge clk);
    #1;
    if (e >= HMAX - 2) begin
      $display("FAIL model_history: edge index %0d, required below %0d", e, HMAX - 2);
      $fatal(1);
    end
    e = e + 1;
    samp[e] = r;
    flip = 1'b1;
    for (int j = e - SS - DC + 1; j <= e - SS; j++)
      if (sync_at(j) === lvl[e-1]) flip = 1'b0;
    lvl[e] = flip ? ~lvl[e-1] : lvl[e-1];
    exp_level   = lvl[e];
    exp_press   = lvl[e] & ~lvl[e-1];
    exp_release = ~lvl[e] & lvl[e-1];
    exp_long    = 1'b0;
`ifdef BTN_LONGPRESS_EN
    if (e >= LC + 1) begin
      exp_long = ~lvl[e-LC-1];
      for (int j = e - LC; j <= e - 1; j++)
        if (!lvl[j]) exp_long = 1'b0;
    end
`endif
    if (press_pulse)   begin press_cnt++;   last_press_e = e;   end
    if (release_pulse) begin release_cnt++; last_release_e = e; end
    if (long_pulse)    begin long_cnt++;    last_long_e = e;    end
  endtask

  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {btn_level, press_pulse, release_pulse, long_pulse});
    end
    apply_reset();
  endtask

  task automatic test_clean_press();
    apply_reset();
    btn_raw = 1'b1;
    repeat (14) begin
      tick();
      n_tests++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        n_fail++;
        $display("FAIL clean_press_cycle e=%0d: got %b, required %b", e,
                 {btn_level, press_pulse, release_pulse, long_pulse},
                 {exp_level, exp_press, exp_release, exp_long});
      end
      if (e == 9) begin
        n_tests++;
        if (btn_level !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_press_early: level at edge 9 got %b, required 0", btn_level);
        end
      end
      if (e == 10) begin
        n_tests++;
        if ({btn_level, press_pulse} !== 2'b11) begin
          n_fail++;
          $display("FAIL clean_press_edge10: level,press got %b, required 11", {btn_level, press_pulse});
        end
      end
    end
    n_tests++;
    if (press_cnt != 1 || release_cnt != 0) begin
      n_fail++;
      $display("FAIL clean_press_counts: press %0d release %0d, required 1 and 0", press_cnt, release_cnt);
    end
  endtask

  task automatic test_glitch();
    for (int hi = 7; hi <= 8; hi++) begin
      apply_reset();
      for (int k = 0; k < hi + 15; k++) begin
        btn_raw = (k < hi);
        tick();
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !==
            {exp_level, exp_press, exp_release, exp_long}) begin
          n_fail++;
          $display("FAIL glitch_cycle hi=%0d e=%0d: got %b, required %b", hi, e,
                   {btn_level, press_pulse, release_pulse, long_pulse},
                   {exp_level, exp_press, exp_release, exp_long});
        end
      end
      n_tests++;
      if (hi == 7) begin
        if (press_cnt != 0 || release_cnt != 0 || btn_level !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_7: press %0d release %0d level %b, required 0 0 0",
                   press_cnt, release_cnt, btn_level);
        end
      end else begin
        if (press_cnt != 1 || release_cnt != 1 || last_press_e != 10 || last_release_e != 18) begin
          n_fail++;
          $display("FAIL glitch_8: press %0d@%0d release %0d@%0d, required 1@10 1@18",
                   press_cnt, last_press_e, release_cnt, last_release_e);
        end
      end
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int k = 0; k < 45; k++) begin
      btn_raw = (k >= 30) ? 1'b1 : (((k / 3) % 2) == 0);
      tick();
      n_tests++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        n_fail++;
        $display("FAIL bounce_cycle e=%0d: got %b, required %b", e,
                 {btn_level, press_pulse, release_pulse, long_pulse},
                 {exp_level, exp_press, exp_release, exp_long});
      end
    end
    n_tests++;
    if (press_cnt != 1 || last_press_e != 40 || release_cnt != 0) begin
      n_fail++;
      $display("FAIL bounce_press: press %0d@%0d release %0d, required 1@40 0",
               press_cnt, last_press_e, release_cnt);
    end
  endtask

  task automatic test_release();
    apply_reset();
    for (int k = 0; k < 28; k++) begin
      btn_raw = (k < 14);
      tick();
      n_tests++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        n_fail++;
        $display("FAIL release_cycle e=%0d: got %b, required %b", e,
                 {btn_level, press_pulse, release_pulse, long_pulse},
                 {exp_level, exp_press, exp_release, exp_long});
      end
    end
    n_tests++;
    if (release_cnt != 1 || last_release_e != 24 || btn_level !== 1'b0) begin
      n_fail++;
      $display("FAIL release_edge: release %0d@%0d level %b, required 1@24 0",
               release_cnt, last_release_e, btn_level);
    end
  endtask

  task automatic test_long_press();
    int hold;
    for (int pass = 0; pass < 2; pass++) begin
      hold = (pass == 0) ? 60 : 30;
      apply_reset();
      for (int k = 0; k < hold + 14; k++) begin
        btn_raw = (k < hold);
        tick();
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !==
            {exp_level, exp_press, exp_release, exp_long}) begin
          n_fail++;
          $display("FAIL long_cycle hold=%0d e=%0d: got %b, required %b", hold, e,
                   {btn_level, press_pulse, release_pulse, long_pulse},
                   {exp_level, exp_press, exp_release, exp_long});
        end
      end
      n_tests++;
`ifdef BTN_LONGPRESS_EN
      if (pass == 0) begin
        if (long_cnt != 1 || last_long_e != 42) begin
          n_fail++;
          $display("FAIL long_60: long %0d@%0d, required 1@42", long_cnt, last_long_e);
        end
      end else if (long_cnt != 0) begin
        n_fail++;
        $display("FAIL long_30: long count %0d, required 0", long_cnt);
      end
`else
      if (long_cnt != 0) begin
        n_fail++;
        $display("FAIL long_disabled hold=%0d: long count %0d, required 0", hold, long_cnt);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    // Reset while the level is high: outputs must clear with no clock edge.
    apply_reset();
    btn_raw = 1'b1;
    repeat (12) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000 || clk !== 1'b1) begin
      n_fail++;
      $display("FAIL async_clear: outputs %b clk %b, required 0000 before the next edge",
               {btn_level, press_pulse, release_pulse, long_pulse}, clk);
    end
    // Reset in the middle of a debounce count with the button held.
    apply_reset();
    btn_raw = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midcount_assert: got %b, required 0000",
               {btn_level, press_pulse, release_pulse, long_pulse});
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midcount_held: got %b, required 0000",
               {btn_level, press_pulse, release_pulse, long_pulse});
    end
    rst_n = 1'b1;
    model_reset();
    repeat (14) begin
      tick();
      n_tests++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !==
          {exp_level, exp_press, exp_release, exp_long}) begin
        n_fail++;
        $display("FAIL midcount_cycle e=%0d: got %b, required %b", e,
                 {btn_level, press_pulse, release_pulse, long_pulse},
                 {exp_level, exp_press, exp_release, exp_long});
      end
    end
    n_tests++;
    if (press_cnt != 1 || last_press_e != 10) begin
      n_fail++;
      $display("FAIL midcount_press: press %0d@%0d, required 1@10", press_cnt, last_press_e);
    end
  endtask

  task automatic test_random();
    int len;
    int both;
    apply_reset();
    both = 0;
    for (int run = 0; run < 40; run++) begin
      btn_raw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 45);
      repeat (len) begin
        tick();
        if (press_pulse && release_pulse) both++;
        n_tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !==
            {exp_level, exp_press, exp_release, exp_long}) begin
          n_fail++;
          $display("FAIL random_cycle e=%0d: got %b, required %b", e,
                   {btn_level, press_pulse, release_pulse, long_pulse},
                   {exp_level, exp_press, exp_release, exp_long});
        end
      end
    end
    n_tests++;
    if (both != 0) begin
      n_fail++;
      $display("FAIL random_exclusive: press and release together %0d times, required 0", both);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_release();
    test_long_press();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
